// File: rtl/game_ctrl.sv
// game_ctrl: menu/countdown/run/over sequencer that turns a local tick and gated
// remote direction strobes into per-snake step pulses, latching result and link loss.
package game_ctrl_pkg;
  typedef enum logic {MENU = 1'b0, GAME = 1'b1} game_mode;
endpackage

module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES       = 6500000,
  parameter int unsigned COUNTDOWN_TICKS   = 3,
  parameter int unsigned MAX_MISSED        = 2,
  parameter int unsigned RESULT_HOLD_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       quit,
  input  logic       rcvdir,
  input  logic       won,
  input  logic       lost,
  input  logic       draw,
  output game_mode   mode,
  output logic       step1,
  output logic       step2,
  output logic       send_dir,
  output logic [1:0] countdown,
  output logic       game_over,
  output logic [1:0] result,
  output logic       link_err
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam int unsigned MW = $clog2(MAX_MISSED + 1);
  localparam int unsigned HW = $clog2(RESULT_HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [MW-1:0] MISSED_MAX  = MW'(MAX_MISSED);
  localparam logic [MW-1:0] MISSED_LAST = MW'(MAX_MISSED - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESULT_HOLD_TICKS - 1);
  localparam logic [1:0]    CD_INIT     = 2'(COUNTDOWN_TICKS);

  typedef enum logic [1:0] {S_MENU, S_COUNTDOWN, S_RUN, S_OVER} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
  logic [MW-1:0]   r_missed, w_missed_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic            r_await, w_await_nxt;
  game_mode        r_mode, w_mode_nxt;
  logic            r_step1, w_step1_nxt;
  logic            r_step2, w_step2_nxt;
  logic            r_send_dir, w_send_dir_nxt;
  logic [1:0]      r_countdown, w_countdown_nxt;
  logic            r_game_over, w_game_over_nxt;
  logic [1:0]      r_result, w_result_nxt;
  logic            r_link_err, w_link_err_nxt;

  logic            w_tick;
  logic            w_outcome;
  logic [1:0]      w_outcome_code;
  logic            w_link_loss;
  logic            w_hold_done;

  assign w_tick         = (r_tick_cnt == TICK_LAST);
  assign w_outcome      = won | lost | draw;
  assign w_outcome_code = draw ? 2'b11 : (won ? 2'b01 : 2'b10);
  // Third unanswered tick (with MAX_MISSED=2) pushes the missed count to its limit.
  assign w_link_loss    = (r_state == S_RUN) && w_tick && !rcvdir && r_await &&
                          (r_missed == MISSED_LAST);
  assign w_hold_done    = w_tick && (r_hold_cnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_MENU;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_MENU:      if (start) w_state_nxt = S_COUNTDOWN;
      S_COUNTDOWN: begin
        if (quit)                                w_state_nxt = S_MENU;
        else if (w_tick && r_countdown == 2'd1) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (quit)                           w_state_nxt = S_MENU;
        else if (w_outcome || w_link_loss)  w_state_nxt = S_OVER;
      end
      S_OVER:      if (quit || start || w_hold_done) w_state_nxt = S_MENU;
      default:     w_state_nxt = S_MENU;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_tick_nxt      = w_tick ? '0 : r_tick_cnt + TW'(1);
    w_mode_nxt      = (w_state_nxt == S_MENU) ? MENU : GAME;
    w_game_over_nxt = (w_state_nxt == S_OVER);
    w_step1_nxt     = 1'b0;
    w_step2_nxt     = 1'b0;
    w_send_dir_nxt  = 1'b0;
    w_countdown_nxt = r_countdown;
    w_result_nxt    = r_result;
    w_link_err_nxt  = r_link_err;
    w_missed_nxt    = r_missed;
    w_await_nxt     = r_await;
    w_hold_nxt      = r_hold_cnt;
    if (w_state_nxt != r_state && (w_state_nxt == S_COUNTDOWN || w_state_nxt == S_RUN))
      w_tick_nxt = '0;
    unique case (r_state)
      S_MENU: begin
        if (start) begin
          w_countdown_nxt = CD_INIT;
          w_result_nxt    = 2'b00;
          w_link_err_nxt  = 1'b0;
          w_missed_nxt    = '0;
          w_await_nxt     = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (quit) begin
          w_result_nxt    = 2'b00;
          w_countdown_nxt = 2'd0;
        end else if (w_tick) begin
          w_countdown_nxt = (r_countdown == 2'd1) ? 2'd0 : r_countdown - 2'd1;
        end
      end
      S_RUN: begin
        w_hold_nxt = '0;
        if (quit) begin
          w_result_nxt = 2'b00;
        end else begin
          w_step1_nxt    = w_tick;
          w_send_dir_nxt = w_tick;
          w_step2_nxt    = rcvdir;
          // A remote direction is credited before the coincident tick re-arms await.
          if (rcvdir) begin
            w_missed_nxt = '0;
            w_await_nxt  = w_tick;
          end else if (w_tick) begin
            if (!r_await)                  w_await_nxt  = 1'b1;
            else if (r_missed != MISSED_MAX) w_missed_nxt = r_missed + MW'(1);
          end
          if (w_outcome) begin
            w_result_nxt = w_outcome_code;
          end else if (w_link_loss) begin
            w_result_nxt   = 2'b10;
            w_link_err_nxt = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (quit)        w_result_nxt = 2'b00;
        else if (w_tick) w_hold_nxt   = r_hold_cnt + HW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_missed    <= '0;
      r_hold_cnt  <= '0;
      r_await     <= 1'b0;
      r_mode      <= MENU;
      r_step1     <= 1'b0;
      r_step2     <= 1'b0;
      r_send_dir  <= 1'b0;
      r_countdown <= 2'd0;
      r_game_over <= 1'b0;
      r_result    <= 2'b00;
      r_link_err  <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick_nxt;
      r_missed    <= w_missed_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_await     <= w_await_nxt;
      r_mode      <= w_mode_nxt;
      r_step1     <= w_step1_nxt;
      r_step2     <= w_step2_nxt;
      r_send_dir  <= w_send_dir_nxt;
      r_countdown <= w_countdown_nxt;
      r_game_over <= w_game_over_nxt;
      r_result    <= w_result_nxt;
      r_link_err  <= w_link_err_nxt;
    end
  end

  assign mode      = r_mode;
  assign step1     = r_step1;
  assign step2     = r_step2;
  assign send_dir  = r_send_dir;
  assign countdown = r_countdown;
  assign game_over = r_game_over;
  assign result    = r_result;
  assign link_err  = r_link_err;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl with small tick parameters.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  localparam int unsigned TC = 4;
  localparam int unsigned CD = 3;
  localparam int unsigned MM = 2;
  localparam int unsigned HT = 2;

  logic       clk = 1'b0;
  logic       rst, start, quit, rcvdir, won, lost, draw;
  game_mode   mode;
  logic       step1, step2, send_dir, game_over, link_err;
  logic [1:0] countdown, result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  game_ctrl #(
    .TICK_CYCLES(TC), .COUNTDOWN_TICKS(CD), .MAX_MISSED(MM), .RESULT_HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .quit(quit), .rcvdir(rcvdir),
    .won(won), .lost(lost), .draw(draw), .mode(mode), .step1(step1),
    .step2(step2), .send_dir(send_dir), .countdown(countdown),
    .game_over(game_over), .result(result), .link_err(link_err)
  );

  // Packed view: {mode, step1, step2, send_dir, countdown, game_over, result, link_err}
  function automatic logic [9:0] ov(input logic m, input logic s1, input logic s2,
                                    input logic sd, input logic [1:0] cd, input logic go,
                                    input logic [1:0] res, input logic le);
    return {m, s1, s2, sd, cd, go, res, le};
  endfunction

  function automatic logic [9:0] obs();
    logic m;
    m = (mode == GAME);
    return {m, step1, step2, send_dir, countdown, game_over, result, link_err};
  endfunction

  task automatic compare(input string tag, input logic [9:0] e);
    checks++;
    assert (obs() === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs(), e);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
    start = 1'b0; quit = 1'b0; rcvdir = 1'b0; won = 1'b0; lost = 1'b0; draw = 1'b0;
    it = sb.pop_front();
    compare(it.tag, it.exp);
  endtask

  // Start pulse, then 3->2->1 countdown at 4-cycle spacing, RUN entry 12 cycles later.
  task automatic start_game();
    start = 1'b1;
    for (int i = 0; i < 12; i++)
      step("countdown", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'(3 - i / 4), 1'b0, 2'b00, 1'b0));
    step("run_entry", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0));
  endtask

  task automatic wait_no_remote(input int upto);
    for (int r = 1; r <= upto; r++)
      step("link_wait", ov(1'b1, r % 4 == 0, 1'b0, r % 4 == 0, 2'd0, 1'b0, 2'b00, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; quit = 1'b0; rcvdir = 1'b0;
    won = 1'b0; lost = 1'b0; draw = 1'b0;
    #1;
    step("reset", '0);
    step("reset", '0);
    rst = 1'b0;
    step("menu_idle", '0);
    rcvdir = 1'b1;
    step("menu_rcvdir_dropped", '0);

    // Game A: normal run with remote answers, then draw+won priority, hold timeout
    start_game();
    for (int r = 1; r <= 80; r++) begin
      logic rc;
      rc = (r % 4 == 2) && (r >= 6);
      rcvdir = rc;
      step("run_normal", ov(1'b1, r % 4 == 0, rc, r % 4 == 0, 2'd0, 1'b0, 2'b00, 1'b0));
    end
    won = 1'b1; draw = 1'b1;
    step("prio_draw", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b11, 1'b0));
    for (int r = 82; r <= 87; r++)
      step("over_hold", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b11, 1'b0));
    step("hold_expire", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 1'b0));
    rcvdir = 1'b1;
    step("menu_result", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b11, 1'b0));

    // Game B: won alone, acknowledged by start
    start_game();
    won = 1'b1;
    step("won_only", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 1'b0));
    start = 1'b1;
    step("ack_start", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01, 1'b0));

    // Game C: no remote directions -> link loss on third tick
    start_game();
    wait_no_remote(11);
    step("link_loss", ov(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'b10, 1'b1));
    for (int r = 13; r <= 19; r++)
      step("link_over", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 1'b1));
    step("link_hold_expire", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b10, 1'b1));

    // Game E: outcome coinciding with link loss wins; link_err cleared by start
    start_game();
    wait_no_remote(11);
    lost = 1'b1;
    step("outcome_over_link", ov(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'b10, 1'b0));
    start = 1'b1;
    step("ack_lost", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b10, 1'b0));

    // Game D: rcvdir coincident with every tick, then quit
    start_game();
    for (int r = 1; r <= 40; r++) begin
      logic s;
      s = (r % 4 == 0);
      rcvdir = s;
      step("simul", ov(1'b1, s, s, s, 2'd0, 1'b0, 2'b00, 1'b0));
    end
    quit = 1'b1;
    step("quit", '0);
    rcvdir = 1'b1;
    step("rcvdir_after_quit", '0);
    step("menu_after_quit", '0);

    // Game F: asynchronous reset mid-run
    start_game();
    wait_no_remote(4);
    rst = 1'b1;
    #1;
    compare("async_rst", '0);
    step("rst_hold", '0);
    step("rst_hold", '0);
    rst = 1'b0;
    step("post_rst", '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
